// File: rtl/resp_stat_pkg.sv
// resp_stat_pkg: shared sizes and FSM state type for the response statistics accumulator
package resp_stat_pkg;
   localparam int NUM_OUTPUTS = 22;
   localparam int CNT_W = 16;
   localparam int IDX_W = 5;
   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_e;
endpackage

// File: rtl/resp_stat_acc_bit_counter.sv
// stat_bit_counter: counts the ones seen on one response bit while enabled
module stat_bit_counter
   import resp_stat_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic             bit_i,
   output logic [CNT_W-1:0] cnt_o
);
   logic [CNT_W-1:0] cnt_q;
   // clear has priority over counting so a new run starts from zero
   always_ff @(posedge clk_i)
      if (rst_i || clr_i) cnt_q <= '0;
      else if (en_i && bit_i) cnt_q <= cnt_q + 1'b1;
   assign cnt_o = cnt_q;
endmodule

// File: rtl/resp_stat_acc.sv
// resp_stat_acc: accumulates per-bit ones counts over a run of responses and reports the majority
module resp_stat_acc
   import resp_stat_pkg::*;
(
   input  logic                   v_in1_v,
   input  logic                   reset,
   input  logic                   start,
   input  logic [CNT_W-1:0]       num_samples,
   input  logic                   resp_valid,
   input  logic [NUM_OUTPUTS-1:0] resp_data,
   output logic                   busy,
   output logic                   done,
   output logic [CNT_W-1:0]       sample_count,
   output logic [NUM_OUTPUTS-1:0] majority,
   input  logic [IDX_W-1:0]       rd_idx,
   output logic [CNT_W-1:0]       rd_count
);
   state_e state_q, state_d;
   logic [CNT_W-1:0] scnt_q, scnt_d, target_q, target_d, rd_q, scnt_n;
   logic [NUM_OUTPUTS-1:0] maj_q, maj_d;
   logic [CNT_W-1:0] ones [NUM_OUTPUTS];
   logic go, accept, last;
   assign go = start && state_q != ACCUM;
   assign accept = state_q == ACCUM && resp_valid;
   assign scnt_n = scnt_q + 1'b1;
   assign last = accept && scnt_n == target_q;
   for (genvar i = 0; i < NUM_OUTPUTS; i++) begin : g_cnt
      stat_bit_counter u_cnt (
         .clk_i(v_in1_v),
         .rst_i(reset),
         .clr_i(go),
         .en_i (accept),
         .bit_i(resp_data[i]),
         .cnt_o(ones[i])
      );
   end
   // next state, run bookkeeping and majority of the counts including the final sample
   always_comb begin
      state_d = state_q;
      scnt_d = accept ? scnt_n : scnt_q;
      target_d = target_q;
      maj_d = maj_q;
      if (go) begin
         state_d = num_samples == '0 ? DONE : ACCUM;
         scnt_d = '0;
         target_d = num_samples;
         maj_d = '0;
      end else if (last) begin
         state_d = DONE;
         for (int i = 0; i < NUM_OUTPUTS; i++)
            maj_d[i] = {ones[i] + CNT_W'(resp_data[i]), 1'b0} > {1'b0, scnt_n};
      end
   end
   // state and result registers, plus the registered counter readback
   always_ff @(posedge v_in1_v)
      if (reset) begin
         state_q <= IDLE;
         scnt_q <= '0;
         target_q <= '0;
         maj_q <= '0;
         rd_q <= '0;
      end else begin
         state_q <= state_d;
         scnt_q <= scnt_d;
         target_q <= target_d;
         maj_q <= maj_d;
         rd_q <= rd_idx < IDX_W'(NUM_OUTPUTS) ? ones[rd_idx] : '0;
      end
   assign busy = state_q == ACCUM;
   assign done = state_q == DONE;
   assign sample_count = scnt_q;
   assign majority = maj_q;
   assign rd_count = rd_q;
endmodule

// File: tb/tb_resp_stat_acc.sv
// tb_resp_stat_acc: directed self-checking bench for resp_stat_acc
module tb_resp_stat_acc;
   logic clk = 0, reset = 1, start = 0, resp_valid = 0;
   logic [15:0] num_samples = 0;
   logic [21:0] resp_data = 0;
   logic [4:0] rd_idx = 0;
   logic busy, done;
   logic [15:0] sample_count, rd_count;
   logic [21:0] majority;
   int checks = 0, errors = 0;
   always #5 clk = ~clk;
   resp_stat_acc dut (
      .v_in1_v(clk), .reset(reset), .start(start), .num_samples(num_samples),
      .resp_valid(resp_valid), .resp_data(resp_data), .busy(busy), .done(done),
      .sample_count(sample_count), .majority(majority), .rd_idx(rd_idx), .rd_count(rd_count)
   );
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic rd(input logic [4:0] idx, input logic [31:0] exp);
      rd_idx = idx;
      tick();
      chk($sformatf("rd_count[%0d]", idx), 32'(rd_count), exp);
   endtask
   task automatic go(input logic [15:0] n);
      start = 1;
      num_samples = n;
      tick();
      start = 0;
   endtask
   task automatic sample(input logic [21:0] d);
      resp_valid = 1;
      resp_data = d;
      tick();
      resp_valid = 0;
   endtask
   initial begin
      tick();
      tick();
      reset = 0;
      chk("rst busy", 32'(busy), 0);
      chk("rst done", 32'(done), 0);
      chk("rst sample_count", 32'(sample_count), 0);
      chk("rst majority", 32'(majority), 0);
      chk("rst rd_count", 32'(rd_count), 0);
      // all-ones run
      go(4);
      chk("ones busy", 32'(busy), 1);
      for (int k = 0; k < 3; k++) sample(22'h3FFFFF);
      chk("ones not done early", 32'(done), 0);
      sample(22'h3FFFFF);
      chk("ones done", 32'(done), 1);
      chk("ones busy off", 32'(busy), 0);
      chk("ones sample_count", 32'(sample_count), 4);
      chk("ones majority", 32'(majority), 32'h3FFFFF);
      for (int i = 0; i < 22; i += 7) rd(5'(i), 4);
      rd(21, 4);
      // tie with gapped valid
      go(4);
      for (int k = 0; k < 4; k++) begin
         if (k == 3) chk("tie not done early", 32'(done), 0);
         sample(k % 2 == 0 ? 22'h200000 : 22'h0);
         if (k < 3) begin
            tick();
            tick();
         end
      end
      chk("tie done", 32'(done), 1);
      chk("tie sample_count", 32'(sample_count), 4);
      chk("tie majority", 32'(majority), 0);
      rd(21, 2);
      rd(20, 0);
      // zero-length run
      go(0);
      chk("zero done", 32'(done), 1);
      chk("zero busy", 32'(busy), 0);
      chk("zero sample_count", 32'(sample_count), 0);
      chk("zero majority", 32'(majority), 0);
      rd(21, 0);
      // abort by reset
      go(10);
      for (int k = 0; k < 5; k++) sample(22'h3FFFFF);
      chk("abort pre sample_count", 32'(sample_count), 5);
      reset = 1;
      start = 1;
      resp_valid = 1;
      tick();
      reset = 0;
      start = 0;
      resp_valid = 0;
      chk("abort busy", 32'(busy), 0);
      chk("abort done", 32'(done), 0);
      chk("abort sample_count", 32'(sample_count), 0);
      rd(0, 0);
      go(1);
      sample(22'h000001);
      chk("after abort done", 32'(done), 1);
      chk("after abort sample_count", 32'(sample_count), 1);
      chk("after abort majority", 32'(majority), 1);
      rd(0, 1);
      // ignored inputs
      go(3);
      sample(22'h3);
      go(0);
      chk("ign start busy", 32'(busy), 1);
      chk("ign start sample_count", 32'(sample_count), 1);
      sample(22'h1);
      sample(22'h1);
      chk("ign done", 32'(done), 1);
      chk("ign sample_count", 32'(sample_count), 3);
      chk("ign majority", 32'(majority), 1);
      sample(22'h3FFFFF);
      chk("ign valid sample_count", 32'(sample_count), 3);
      rd(0, 3);
      rd(1, 1);
      rd(5, 0);
      rd(25, 0);
      // restart from DONE with simultaneous valid
      resp_valid = 1;
      resp_data = 22'h3FFFFF;
      go(2);
      resp_valid = 0;
      chk("restart busy", 32'(busy), 1);
      chk("restart sample_count", 32'(sample_count), 0);
      chk("restart majority", 32'(majority), 0);
      rd(0, 0);
      sample(22'h2);
      sample(22'h2);
      chk("restart done", 32'(done), 1);
      chk("restart final count", 32'(sample_count), 2);
      chk("restart majority final", 32'(majority), 2);
      rd(1, 2);
      rd(0, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
